// File: rtl/data_mem.sv
// Byte-addressable big-endian data memory for the load/store path.
// Byte/half/word access, sign/zero extension, error checking, LATENCY-cycle registered response.
module data_mem #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DEPTH_BYTES = 1024,
    parameter int unsigned LATENCY     = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int unsigned IDX_W = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;
    localparam int unsigned AW1   = ADDR_W + 1;
    localparam int unsigned CNT_W = 3;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    localparam logic [ADDR_W:0] DEPTH_L = AW1'(DEPTH_BYTES);

    logic [7:0] mem [DEPTH_BYTES];

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      pend_rdata_q, pend_rdata_d;
    logic             pend_err_q, pend_err_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [31:0]      rsp_rdata_q, rsp_rdata_d;
    logic             rsp_err_q, rsp_err_d;

    logic             accept;
    logic [2:0]       nbytes;
    logic [ADDR_W:0]  end_addr;
    logic             misalign;
    logic             req_err;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] lane_idx [4];
    logic [7:0]       rd_b [4];
    logic             sign;
    logic [31:0]      ld_val;
    logic [31:0]      ld_res;
    logic [3:0]       wr_en;
    logic [7:0]       wr_data [4];

    assign req_ready = (state_q == S_IDLE);
    assign accept    = req_valid & req_ready & rst_n;

    // Request decode: size, alignment and range check at ADDR_W+1 bits so the end address cannot wrap
    always_comb begin
        nbytes = 3'd4;
        case (req_size)
            2'b00:   nbytes = 3'd1;
            2'b01:   nbytes = 3'd2;
            default: nbytes = 3'd4;
        endcase
        end_addr = {1'b0, req_addr} + AW1'(nbytes);
        misalign = ((req_size == 2'b01) && req_addr[0]) ||
                   ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
        req_err  = (req_size == 2'b11) || misalign || (end_addr > DEPTH_L);
        idx      = IDX_W'(req_addr);
    end

    // Big-endian read lanes: lane 0 is the addressed byte (most significant)
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            lane_idx[i] = IDX_W'(idx + IDX_W'(i));
            rd_b[i]     = mem[lane_idx[i]];
        end
        sign   = ~req_unsigned & rd_b[0][7];
        ld_val = {rd_b[0], rd_b[1], rd_b[2], rd_b[3]};
        case (req_size)
            2'b00:   ld_val = {{24{sign}}, rd_b[0]};
            2'b01:   ld_val = {{16{sign}}, rd_b[0], rd_b[1]};
            default: ld_val = {rd_b[0], rd_b[1], rd_b[2], rd_b[3]};
        endcase
        ld_res = (req_we || req_err) ? 32'h0 : ld_val;
    end

    // Store lane enables; right-justified write data mapped big-endian onto the lanes
    always_comb begin
        wr_en = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            wr_data[i] = 8'h00;
        end
        if (accept && req_we && !req_err) begin
            case (req_size)
                2'b00: begin
                    wr_en      = 4'b0001;
                    wr_data[0] = req_wdata[7:0];
                end
                2'b01: begin
                    wr_en      = 4'b0011;
                    wr_data[0] = req_wdata[15:8];
                    wr_data[1] = req_wdata[7:0];
                end
                2'b10: begin
                    wr_en = 4'b1111;
                    for (int i = 0; i < 4; i++) begin
                        wr_data[i] = req_wdata[8*(3-i) +: 8];
                    end
                end
                default: wr_en = 4'b0000;
            endcase
        end
    end

    // Storage is not reset; contents persist across rst_n
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wr_en[i]) begin
                mem[lane_idx[i]] <= wr_data[i];
            end
        end
    end

    // Next-state and response logic
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pend_rdata_d = pend_rdata_q;
        pend_err_d   = pend_err_q;
        rsp_valid_d  = 1'b0;
        rsp_rdata_d  = rsp_rdata_q;
        rsp_err_d    = rsp_err_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = ld_res;
                        rsp_err_d   = req_err;
                    end else begin
                        state_d      = S_BUSY;
                        cnt_d        = CNT_W'(LATENCY - 1);
                        pend_rdata_d = ld_res;
                        pend_err_d   = req_err;
                    end
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = pend_rdata_q;
                    rsp_err_d   = pend_err_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            pend_rdata_q <= '0;
            pend_err_q   <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pend_rdata_q <= pend_rdata_d;
            pend_err_q   <= pend_err_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_mem.sv
// Scoreboard bench for data_mem: three instances at LATENCY 1, 3 and 4 exercised one at a time.
module tb_data_mem;

    typedef struct {
        string       nm;
        int          inst;
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        req_valid    [3];
    logic        req_ready    [3];
    logic        req_we       [3];
    logic [1:0]  req_size     [3];
    logic        req_unsigned [3];
    logic [31:0] req_addr     [3];
    logic [31:0] req_wdata    [3];
    logic        rsp_valid    [3];
    logic [31:0] rsp_rdata    [3];
    logic        rsp_err      [3];

    exp_t sb[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;
    int   last_acc = 0;
    int   last_low = 0;

    function automatic int lat(input int g);
        return (g == 0) ? 1 : ((g == 1) ? 3 : 4);
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        data_mem #(
            .ADDR_W      (32),
            .DEPTH_BYTES (1024),
            .LATENCY     ((g == 0) ? 1 : ((g == 1) ? 3 : 4))
        ) u_dut (
            .clk          (clk),
            .rst_n        (rst_n),
            .req_valid    (req_valid[g]),
            .req_ready    (req_ready[g]),
            .req_we       (req_we[g]),
            .req_size     (req_size[g]),
            .req_unsigned (req_unsigned[g]),
            .req_addr     (req_addr[g]),
            .req_wdata    (req_wdata[g]),
            .rsp_valid    (rsp_valid[g]),
            .rsp_rdata    (rsp_rdata[g]),
            .rsp_err      (rsp_err[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", nm, act, req);
        end
    endtask

    // Monitor: every response strobe pops one expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            for (int g = 0; g < 3; g++) begin
                if (rsp_valid[g] === 1'b1) begin
                    if (sb.size() == 0) begin
                        n_vec++;
                        n_bad++;
                        $display("FAIL unexpected_rsp: dut %0d strobed at cycle %0d, required no response", g, cyc);
                    end else begin
                        e = sb.pop_front();
                        chk({e.nm, ".dut"}, 32'(g), 32'(e.inst));
                        chk({e.nm, ".rdata"}, rsp_rdata[g], e.rdata);
                        chk({e.nm, ".err"}, 32'(rsp_err[g]), 32'(e.err));
                        chk({e.nm, ".cycle"}, 32'(cyc), 32'(e.cyc));
                        chk({e.nm, ".ready"}, 32'(req_ready[g]), 32'd1);
                    end
                end
            end
        end
    end

    task automatic issue(input int g, input string nm, input logic we, input logic [1:0] sz,
                         input logic uns, input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] er, input logic ee, input bit push);
        int n;
        exp_t e;
        @(negedge clk);
        req_valid[g]    = 1'b1;
        req_we[g]       = we;
        req_size[g]     = sz;
        req_unsigned[g] = uns;
        req_addr[g]     = a;
        req_wdata[g]    = wd;
        n = 0;
        while (req_ready[g] !== 1'b1 && n < 20) begin
            n++;
            @(negedge clk);
        end
        last_low = n;
        if (n >= 20) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s: req_ready stayed 0 for %0d cycles, required 1", nm, n);
        end else begin
            last_acc = cyc + 1;
            if (push) begin
                e.nm = nm; e.inst = g; e.rdata = er; e.err = ee; e.cyc = cyc + lat(g);
                sb.push_back(e);
            end
        end
        @(posedge clk);
    endtask

    task automatic st(input int g, input string nm, input logic [1:0] sz, input logic [31:0] a,
                      input logic [31:0] wd, input logic ee);
        issue(g, nm, 1'b1, sz, 1'b0, a, wd, 32'h0, ee, 1'b1);
    endtask

    task automatic ld(input int g, input string nm, input logic [1:0] sz, input logic uns,
                      input logic [31:0] a, input logic [31:0] er, input logic ee);
        issue(g, nm, 1'b0, sz, uns, a, 32'h0, er, ee, 1'b1);
    endtask

    task automatic idle_drain(input int g);
        int n;
        @(negedge clk);
        req_valid[g] = 1'b0;
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            n++;
            @(negedge clk);
        end
        if (sb.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain: %0d responses outstanding, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic chk_reset_outs(input int g, input string nm);
        chk({nm, ".rsp_valid"}, 32'(rsp_valid[g]), 32'd0);
        chk({nm, ".rsp_rdata"}, rsp_rdata[g], 32'd0);
        chk({nm, ".rsp_err"}, 32'(rsp_err[g]), 32'd0);
        chk({nm, ".req_ready"}, 32'(req_ready[g]), 32'd1);
    endtask

    task automatic l3_load(input string nm, input logic [1:0] sz, input logic uns,
                           input logic [31:0] a, input logic [31:0] er, input int prev_acc);
        ld(1, nm, sz, uns, a, er, 1'b0);
        chk({nm, ".ready_low"}, 32'(last_low), 32'd2);
        chk({nm, ".spacing"}, 32'(last_acc - prev_acc), 32'd3);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int prev;
        rst_n = 1'b1;
        for (int g = 0; g < 3; g++) begin
            req_valid[g] = 1'b0; req_we[g] = 1'b0; req_size[g] = 2'b00;
            req_unsigned[g] = 1'b0; req_addr[g] = 32'h0; req_wdata[g] = 32'h0;
        end
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outs(0, "rst0");
        chk_reset_outs(1, "rst1");
        chk_reset_outs(2, "rst2");
        rst_n = 1'b1;
        @(negedge clk);

        // LATENCY 1: basic big-endian access and extension
        st(0, "st_w10",   2'b10, 32'h10, 32'hDEADBEEF, 1'b0);
        ld(0, "ld_w10",   2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0);
        ld(0, "ld_b10",   2'b00, 1'b0, 32'h10, 32'hFFFFFFDE, 1'b0);
        ld(0, "ld_b13",   2'b00, 1'b0, 32'h13, 32'hFFFFFFEF, 1'b0);
        ld(0, "ld_hu12",  2'b01, 1'b1, 32'h12, 32'h0000BEEF, 1'b0);
        ld(0, "ld_hs12",  2'b01, 1'b0, 32'h12, 32'hFFFFBEEF, 1'b0);
        st(0, "st_b11",   2'b00, 32'h11, 32'h0000007F, 1'b0);
        ld(0, "ld_w10b",  2'b10, 1'b0, 32'h10, 32'hDE7FBEEF, 1'b0);

        // Errors leave memory untouched and return zero data
        st(0, "st_w20",   2'b10, 32'h20, 32'h11223344, 1'b0);
        st(0, "st_w3fc",  2'b10, 32'h3FC, 32'hCAFEF00D, 1'b0);
        st(0, "st_mis22", 2'b10, 32'h22, 32'hAAAAAAAA, 1'b1);
        ld(0, "ld_mis05", 2'b01, 1'b0, 32'h05, 32'h0, 1'b1);
        st(0, "st_sz3",   2'b11, 32'h20, 32'hFFFFFFFF, 1'b1);
        ld(0, "ld_sz3",   2'b11, 1'b0, 32'h20, 32'h0, 1'b1);
        st(0, "st_w3fe",  2'b10, 32'h3FE, 32'h99999999, 1'b1);
        ld(0, "ld_b400",  2'b00, 1'b1, 32'h400, 32'h0, 1'b1);
        ld(0, "ld_bwrap", 2'b00, 1'b1, 32'hFFFFFFFF, 32'h0, 1'b1);
        ld(0, "ld_h3fe",  2'b01, 1'b0, 32'h3FE, 32'hFFFFF00D, 1'b0);
        ld(0, "ld_w20",   2'b10, 1'b0, 32'h20, 32'h11223344, 1'b0);
        ld(0, "ld_w3fc",  2'b10, 1'b0, 32'h3FC, 32'hCAFEF00D, 1'b0);
        ld(0, "ld_b3ff",  2'b00, 1'b1, 32'h3FF, 32'h0000000D, 1'b0);

        // Back-to-back store/load at one address
        st(0, "alt_st1",  2'b10, 32'h40, 32'h01020304, 1'b0);
        ld(0, "alt_ld1",  2'b10, 1'b0, 32'h40, 32'h01020304, 1'b0);
        st(0, "alt_st2",  2'b01, 32'h40, 32'h00001234, 1'b0);
        ld(0, "alt_ld2",  2'b10, 1'b0, 32'h40, 32'h12340304, 1'b0);
        st(0, "alt_st3",  2'b00, 32'h43, 32'h0000009C, 1'b0);
        ld(0, "alt_ld3",  2'b10, 1'b0, 32'h40, 32'h1234039C, 1'b0);
        ld(0, "alt_ld4",  2'b00, 1'b0, 32'h43, 32'hFFFFFF9C, 1'b0);
        idle_drain(0);

        // LATENCY 3: valid held high, one acceptance every three cycles
        st(1, "l3_st0", 2'b10, 32'h0, 32'h0BADF00D, 1'b0);
        st(1, "l3_st4", 2'b10, 32'h4, 32'h55AA55AA, 1'b0);
        chk("l3_st4.ready_low", 32'(last_low), 32'd2);
        prev = last_acc;
        l3_load("l3_ld0", 2'b10, 1'b0, 32'h0, 32'h0BADF00D, prev);
        prev = last_acc;
        l3_load("l3_ld4", 2'b10, 1'b0, 32'h4, 32'h55AA55AA, prev);
        prev = last_acc;
        l3_load("l3_ld2", 2'b01, 1'b1, 32'h2, 32'h0000F00D, prev);
        prev = last_acc;
        l3_load("l3_ld5", 2'b00, 1'b0, 32'h5, 32'hFFFFFFAA, prev);
        idle_drain(1);

        // LATENCY 4: reset while a load is in flight
        st(2, "l4_st8", 2'b10, 32'h8, 32'h13579BDF, 1'b0);
        ld(2, "l4_ld8", 2'b10, 1'b0, 32'h8, 32'h13579BDF, 1'b0);
        idle_drain(2);
        issue(2, "l4_drop", 1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        req_valid[2] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1 chk_reset_outs(2, "l4_rst");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk_reset_outs(2, "l4_post");
        ld(2, "l4_ld8b", 2'b10, 1'b0, 32'h8, 32'h13579BDF, 1'b0);
        ld(2, "l4_ldbb", 2'b00, 1'b1, 32'hB, 32'h000000DF, 1'b0);
        idle_drain(2);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
